// File: rtl/mem_access_unit.sv
// Memory sequencer between the control unit and a 512x32 synchronous RAM.
// Optional build macro ADDR_RANGE_CHECK_EN faults any MAR value outside the RAM address range.
module mem_access_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  Mem_Read,
   input  logic                  Mem_Write,
   input  logic [DATA_WIDTH-1:0] MAR_q,
   input  logic [DATA_WIDTH-1:0] MDR_q,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  mem_busy,
   output logic                  mem_done,
   output logic                  addr_fault
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                  state;
   logic                    read_prev;
   logic                    write_prev;
   logic [3:0]              wait_cnt;
   logic                    cur_write;

   logic                    pend_valid;
   logic                    pend_write;
   logic                    pend_fault;
   logic [ADDR_WIDTH-1:0]   pend_addr;
   logic [DATA_WIDTH-1:0]   pend_data;

   logic                    rd_edge;
   logic                    wr_edge;
   logic                    req_edge;
   logic                    req_fault;

   logic                    launch_valid;
   logic                    launch_write;
   logic                    launch_fault;
   logic [ADDR_WIDTH-1:0]   launch_addr;
   logic [DATA_WIDTH-1:0]   launch_data;
   logic                    finish_now;
   logic                    capture_now;

   assign rd_edge  = Mem_Read  & ~read_prev;
   assign wr_edge  = Mem_Write & ~write_prev;
   assign req_edge = rd_edge | wr_edge;

`ifdef ADDR_RANGE_CHECK_EN
   assign req_fault = |MAR_q[DATA_WIDTH-1:ADDR_WIDTH];
`else
   logic unused_mar_hi;
   assign unused_mar_hi = |MAR_q[DATA_WIDTH-1:ADDR_WIDTH];
   assign req_fault     = 1'b0;
`endif

   // Pick the request to start: a fresh edge from IDLE, or from DONE the pending slot first.
   always_comb begin
      launch_valid = 1'b0;
      launch_write = 1'b0;
      launch_fault = 1'b0;
      launch_addr  = MAR_q[ADDR_WIDTH-1:0];
      launch_data  = MDR_q;
      if (state == IDLE) begin
         launch_valid = req_edge;
         launch_write = wr_edge;
         launch_fault = req_fault;
      end else if (state == DONE) begin
         if (pend_valid) begin
            launch_valid = 1'b1;
            launch_write = pend_write;
            launch_fault = pend_fault;
            launch_addr  = pend_addr;
            launch_data  = pend_data;
         end else begin
            launch_valid = req_edge;
            launch_write = wr_edge;
            launch_fault = req_fault;
         end
      end
   end

   // In DONE with a full slot the slot is freed this cycle, so a new edge can refill it.
   always_comb begin
      finish_now  = ((state == ACCESS) && (WAIT_STATES == 0)) ||
                    ((state == WAIT) && (wait_cnt == 4'd0));
      capture_now = req_edge &&
                    ((((state == ACCESS) || (state == WAIT)) && !pend_valid) ||
                     ((state == DONE) && pend_valid));
   end

   // Sequencer FSM; every output is a flop so the RAM and control unit see clean strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         read_prev  <= 1'b0;
         write_prev <= 1'b0;
         wait_cnt   <= 4'd0;
         cur_write  <= 1'b0;
         pend_valid <= 1'b0;
         pend_write <= 1'b0;
         pend_fault <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         mem_busy   <= 1'b0;
         mem_done   <= 1'b0;
         addr_fault <= 1'b0;
      end else begin
         read_prev  <= Mem_Read;
         write_prev <= Mem_Write;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         rd_valid   <= 1'b0;
         mem_done   <= 1'b0;
         addr_fault <= 1'b0;

         case (state)
            IDLE: begin
               mem_busy <= 1'b0;
            end
            ACCESS: begin
               if (WAIT_STATES > 0) begin
                  state    <= WAIT;
                  wait_cnt <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               state    <= IDLE;
               mem_busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               mem_busy <= 1'b0;
            end
         endcase

         if (capture_now) begin
            pend_valid <= 1'b1;
            pend_write <= wr_edge;
            pend_fault <= req_fault;
            pend_addr  <= MAR_q[ADDR_WIDTH-1:0];
            pend_data  <= MDR_q;
         end else if (state == DONE) begin
            pend_valid <= 1'b0;
         end

         if (finish_now) begin
            state    <= DONE;
            mem_done <= 1'b1;
            if (!cur_write) begin
               rd_valid <= 1'b1;
               rd_data  <= ram_rdata;
            end
         end

         // A faulted request skips the RAM entirely and completes on the next cycle.
         if (launch_valid) begin
            ram_addr  <= launch_addr;
            ram_wdata <= launch_data;
            cur_write <= launch_write;
            mem_busy  <= 1'b1;
            if (launch_fault) begin
               state      <= DONE;
               mem_done   <= 1'b1;
               addr_fault <= 1'b1;
               if (!launch_write) begin
                  rd_valid <= 1'b1;
                  rd_data  <= '0;
               end
            end else begin
               state  <= ACCESS;
               ram_en <= 1'b1;
               ram_we <= launch_write;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 512x32 synchronous RAM.
// Build with ADDR_RANGE_CHECK_EN defined to exercise the fault path.
module tb_mem_access_unit;

   logic        clk;
   logic        reset_n;
   logic        Mem_Read;
   logic        Mem_Write;
   logic [31:0] MAR_q;
   logic [31:0] MDR_q;
   logic [31:0] ram_rdata;
   logic [8:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_en;
   logic        ram_we;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        mem_busy;
   logic        mem_done;
   logic        addr_fault;

   logic [31:0] ram [0:511];
   int          checks;
   int          failures;
   int          en_count;
   int          we_count;
   int          done_count;
   int          base_en;
   int          base_we;
   int          base_done;

   mem_access_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Mem_Read   (Mem_Read),
      .Mem_Write  (Mem_Write),
      .MAR_q      (MAR_q),
      .MDR_q      (MDR_q),
      .ram_rdata  (ram_rdata),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .mem_busy   (mem_busy),
      .mem_done   (mem_done),
      .addr_fault (addr_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: registered read data, write on enable plus strobe.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end
   end

   initial begin
      en_count   = 0;
      we_count   = 0;
      done_count = 0;
   end

   always @(negedge clk) begin
      if (ram_en)   en_count   = en_count + 1;
      if (ram_we)   we_count   = we_count + 1;
      if (mem_done) done_count = done_count + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         failures = failures + 1;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] mar, input logic [31:0] mdr);
      Mem_Read  = rd;
      Mem_Write = wr;
      MAR_q     = mar;
      MDR_q     = mdr;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_addr"},  32'(ram_addr),   32'h0);
      checkOutput({tag, "_wdata"}, ram_wdata,       32'h0);
      checkOutput({tag, "_en"},    32'(ram_en),     32'h0);
      checkOutput({tag, "_we"},    32'(ram_we),     32'h0);
      checkOutput({tag, "_rdata"}, rd_data,         32'h0);
      checkOutput({tag, "_rvalid"},32'(rd_valid),   32'h0);
      checkOutput({tag, "_busy"},  32'(mem_busy),   32'h0);
      checkOutput({tag, "_done"},  32'(mem_done),   32'h0);
      checkOutput({tag, "_fault"}, 32'(addr_fault), 32'h0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      ram_rdata = 32'h0;
      for (int i = 0; i < 512; i++) ram[i] = 32'h0;
      ram[9'h005] = 32'hDEADBEEF;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      reset_n = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      reset_n = 1'b1;
      tick();

      $display("[TB] read with one wait state");
      applyStimulus(1'b1, 1'b0, 32'h5, 32'h0);
      tick();
      checkOutput("rd_access_en",   32'(ram_en),   32'h1);
      checkOutput("rd_access_we",   32'(ram_we),   32'h0);
      checkOutput("rd_access_addr", 32'(ram_addr), 32'h5);
      checkOutput("rd_access_busy", 32'(mem_busy), 32'h1);
      tick();
      checkOutput("rd_wait_en",     32'(ram_en),   32'h0);
      checkOutput("rd_wait_done",   32'(mem_done), 32'h0);
      tick();
      checkOutput("rd_done",        32'(mem_done), 32'h1);
      checkOutput("rd_valid",       32'(rd_valid), 32'h1);
      checkOutput("rd_data",        rd_data,       32'hDEADBEEF);
      tick();
      checkOutput("rd_idle_busy",   32'(mem_busy), 32'h0);
      checkOutput("rd_idle_done",   32'(mem_done), 32'h0);
      checkOutput("rd_hold_data",   rd_data,       32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 32'h5, 32'h0);
      tick();

      $display("[TB] write to top address and read back");
      base_we = we_count;
      applyStimulus(1'b0, 1'b1, 32'h1FF, 32'h12345678);
      tick();
      checkOutput("wr_we",    32'(ram_we),   32'h1);
      checkOutput("wr_en",    32'(ram_en),   32'h1);
      checkOutput("wr_addr",  32'(ram_addr), 32'h1FF);
      checkOutput("wr_wdata", ram_wdata,     32'h12345678);
      applyStimulus(1'b0, 1'b0, 32'h1FF, 32'h12345678);
      tick();
      tick();
      checkOutput("wr_done",   32'(mem_done), 32'h1);
      checkOutput("wr_rvalid", 32'(rd_valid), 32'h0);
      tick();
      checkOutput("wr_we_cycles", 32'(we_count - base_we), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h1FF, 32'h0);
      tick();
      tick();
      tick();
      checkOutput("wr_readback", rd_data,       32'h12345678);
      checkOutput("wr_rb_valid", 32'(rd_valid), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("[TB] held level gives one access");
      base_en   = en_count;
      base_done = done_count;
      applyStimulus(1'b1, 1'b0, 32'h5, 32'h0);
      repeat (10) tick();
      applyStimulus(1'b0, 1'b0, 32'h5, 32'h0);
      tick();
      tick();
      checkOutput("held_en_cycles",   32'(en_count - base_en),     32'h1);
      checkOutput("held_done_pulses", 32'(done_count - base_done), 32'h1);

      $display("[TB] pending request during WAIT");
      base_done = done_count;
      applyStimulus(1'b1, 1'b0, 32'h5, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h5, 32'h0);
      tick();
      checkOutput("pend_wait_busy", 32'(mem_busy), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h1FF, 32'h0);
      tick();
      checkOutput("pend_first_done", 32'(mem_done), 32'h1);
      checkOutput("pend_first_data", rd_data,       32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("pend_second_busy", 32'(mem_busy), 32'h1);
      checkOutput("pend_second_en",   32'(ram_en),   32'h1);
      checkOutput("pend_second_addr", 32'(ram_addr), 32'h1FF);
      tick();
      checkOutput("pend_wait2_busy",  32'(mem_busy), 32'h1);
      tick();
      checkOutput("pend_second_done", 32'(mem_done), 32'h1);
      checkOutput("pend_second_data", rd_data,       32'h12345678);
      tick();
      checkOutput("pend_idle_busy",   32'(mem_busy), 32'h0);
      checkOutput("pend_done_pulses", 32'(done_count - base_done), 32'h2);

      $display("[TB] simultaneous read and write edges");
      applyStimulus(1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
      tick();
      checkOutput("both_we",   32'(ram_we),   32'h1);
      checkOutput("both_addr", 32'(ram_addr), 32'h10);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      checkOutput("both_done",   32'(mem_done), 32'h1);
      checkOutput("both_rvalid", 32'(rd_valid), 32'h0);
      checkOutput("both_rdata",  rd_data,       32'h12345678);
      tick();
      checkOutput("both_ram",    ram[9'h010],   32'hCAFEF00D);

      $display("[TB] reset during WAIT");
      applyStimulus(1'b1, 1'b0, 32'h5, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h5, 32'h0);
      tick();
      checkOutput("rst_pre_busy", 32'(mem_busy), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      checkAllZero("rst_async");
      tick();
      reset_n = 1'b1;
      tick();
      checkOutput("rst_after_busy", 32'(mem_busy), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h5, 32'h0);
      tick();
      checkOutput("rst_next_en", 32'(ram_en), 32'h1);
      tick();
      tick();
      checkOutput("rst_next_done", 32'(mem_done), 32'h1);
      checkOutput("rst_next_data", rd_data,       32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("[TB] out-of-range MAR");
      applyStimulus(1'b1, 1'b0, 32'h00000205, 32'h0);
      tick();
`ifdef ADDR_RANGE_CHECK_EN
      checkOutput("oor_fault",  32'(addr_fault), 32'h1);
      checkOutput("oor_done",   32'(mem_done),   32'h1);
      checkOutput("oor_en",     32'(ram_en),     32'h0);
      checkOutput("oor_rvalid", 32'(rd_valid),   32'h1);
      checkOutput("oor_rdata",  rd_data,         32'h0);
      tick();
      checkOutput("oor_idle_busy", 32'(mem_busy), 32'h0);
`else
      checkOutput("wrap_en",    32'(ram_en),     32'h1);
      checkOutput("wrap_addr",  32'(ram_addr),   32'h5);
      checkOutput("wrap_fault", 32'(addr_fault), 32'h0);
      tick();
      tick();
      checkOutput("wrap_done",  32'(mem_done),   32'h1);
      checkOutput("wrap_rdata", rd_data,         32'hDEADBEEF);
`endif
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
